// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory access unit:
// access sizes, FSM states and alignment helpers.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam int DW_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_e;

    function automatic logic is_misaligned(input logic [2:0] off,
                                           input logic [1:0] sz);
        logic m;
        unique case (sz)
            SZ_B:    m = 1'b0;
            SZ_H:    m = off[0];
            SZ_W:    m = |off[1:0];
            default: m = |off;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] sz);
        logic [63:0] m;
        unique case (sz)
            SZ_B:    m = 64'h0000_0000_0000_00ff;
            SZ_H:    m = 64'h0000_0000_0000_ffff;
            SZ_W:    m = 64'h0000_0000_ffff_ffff;
            default: m = 64'hffff_ffff_ffff_ffff;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response channel plus memory bus of the access unit.
// master = the unit itself, slave = pipeline and memory around it.
interface mem_access_unit_if #(parameter int XLEN = 64);

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            MEM_V;
    logic            we;
    logic [1:0]      size;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] mem_data;
    logic            v_mem_stall;
    logic [XLEN-1:0] data_out;

    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready,
        output MEM_V, we, size, address, mem_data,
        input  v_mem_stall, data_out,
        output resp_valid, resp_data, resp_err
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready,
        input  MEM_V, we, size, address, mem_data,
        output v_mem_stall, data_out,
        input  resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/load_align.sv
// Extracts a byte/half/word/doubleword from a read doubleword
// and sign- or zero-extends it to the full width.
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      off,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] sh;

    assign sh = data >> {off, 3'b000};

    always_comb begin
        result = sh;
        unique case (size)
            SZ_B: result = is_unsigned ? {56'd0, sh[7:0]}
                                       : {{56{sh[7]}}, sh[7:0]};
            SZ_H: result = is_unsigned ? {48'd0, sh[15:0]}
                                       : {{48{sh[15]}}, sh[15:0]};
            SZ_W: result = is_unsigned ? {32'd0, sh[31:0]}
                                       : {{32{sh[31]}}, sh[31:0]};
            default: result = sh;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, doubleword-aligned memory bus,
// sub-doubleword stores at nonzero offsets done as read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic              CLK,
    input logic              reset,
    mem_access_unit_if.master bus
);

    localparam int OFF_W = $clog2(DW_BYTES);

    state_e state, state_nxt;

    logic             r_we;
    logic [1:0]       r_size;
    logic             r_uns;
    logic             r_err;
    logic [XLEN-1:0]  r_addr;
    logic [XLEN-1:0]  r_wdata;
    logic [XLEN-1:0]  r_rmw;
    logic [XLEN-1:0]  r_resp;

    logic             accept;
    logic             mis;
    logic             stall;
    logic             mem_phase;
    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  ld_val;
    logic [XLEN-1:0]  lmask;
    logic [XLEN-1:0]  merged;

    assign accept = bus.req_valid & bus.req_ready;
    assign mis    = is_misaligned(bus.req_addr[2:0], bus.req_size);
    assign stall  = bus.v_mem_stall;
    assign off    = r_addr[OFF_W-1:0];

    load_align #(.XLEN(XLEN)) u_align (
        .data        (bus.data_out),
        .off         (off),
        .size        (r_size),
        .is_unsigned (r_uns),
        .result      (ld_val)
    );

    // Memory only writes from lane 0, so the RMW write is always a full doubleword.
    assign lmask  = lane_mask(r_size) << {off, 3'b000};
    assign merged = (r_rmw & ~lmask)
                  | ((r_wdata << {off, 3'b000}) & lmask);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (mis)
                        state_nxt = RESP;
                    else if (!bus.req_we)
                        state_nxt = READ;
                    else if (bus.req_addr[2:0] == 3'd0)
                        state_nxt = WRITE;
                    else
                        state_nxt = RMW_RD;
                end
            end
            READ:    if (!stall) state_nxt = RESP;
            WRITE:   if (!stall) state_nxt = RESP;
            RMW_RD:  if (!stall) state_nxt = RMW_WR;
            RMW_WR:  if (!stall) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            r_we    <= 1'b0;
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rmw   <= '0;
            r_resp  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_we    <= bus.req_we;
                r_size  <= bus.req_size;
                r_uns   <= bus.req_unsigned;
                r_err   <= mis;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_resp  <= '0;
            end
            if (state == READ && !stall)
                r_resp <= ld_val;
            if (state == RMW_RD && !stall)
                r_rmw <= bus.data_out;
        end
    end

    assign mem_phase = (state == READ) || (state == WRITE)
                    || (state == RMW_RD) || (state == RMW_WR);

    assign bus.req_ready  = (state == IDLE);
    assign bus.MEM_V      = mem_phase;
    assign bus.we         = r_we && ((state == WRITE) || (state == RMW_WR));
    assign bus.address    = mem_phase ? {r_addr[XLEN-1:3], 3'b000} : '0;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = (state == RESP) && r_err;
    assign bus.resp_data  = r_resp;

    always_comb begin
        bus.size     = SZ_B;
        bus.mem_data = '0;
        unique case (state)
            READ:   bus.size = r_size;
            WRITE: begin
                bus.size     = r_size;
                bus.mem_data = r_wdata;
            end
            RMW_RD: bus.size = SZ_D;
            RMW_WR: begin
                bus.size     = SZ_D;
                bus.mem_data = merged;
            end
            default: ;
        endcase
    end

endmodule
